mux16_rr_arbiter: RTL

- Round-robin arbiter and select sequencer for the 16-to-1 multiplexer datapath.
- Shares the mux between 16 single-bit requesters.
- Produces the registered 4-bit select S16, a one-hot Grant, and the muxed output bit f = W[S16] while a grant is active.
- Tenure per grant is bounded so that no requester starves the others.

---
 rtl/mux16_rr_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter / select sequencer for the 16:1 mux datapath.
// Optional MUX16_ARB_LOCK_EN adds a Lock input that extends tenure.
module mux16_rr_arbiter #(
    parameter int MAXHOLD = 4
) (
    input  logic        Clock,
    input  logic        Resetn,
`ifdef MUX16_ARB_LOCK_EN
    input  logic        Lock,
`endif
    input  logic [0:15] Req,
    input  logic [0:15] W,
    output logic [0:15] Grant,
    output logic [3:0]  S16,
    output logic        Valid,
    output logic        f
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] LAST = 4'(MAXHOLD - 1);

    state_t      state, state_n;
    logic [0:15] grant_n;
    logic [3:0]  s16_n;
    logic        valid_n;
    logic [3:0]  cnt, cnt_n;
    logic [3:0]  ptr, ptr_n;

    logic [3:0]  win;
    logic [3:0]  idx;
    logic        any;
    logic        hold_ok;
    logic        load;

    // Scan upward from ptr; while granted, ptr = holder+1 so holder is last.
    always_comb begin
        win = '0;
        any = 1'b0;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            idx = ptr + 4'(i);
            if (!any && Req[idx]) begin
                any = 1'b1;
                win = idx;
            end
        end
    end

    always_comb begin
        hold_ok = (cnt < LAST);
`ifdef MUX16_ARB_LOCK_EN
        hold_ok = hold_ok | Lock;
`endif
    end

    always_comb begin
        state_n = state;
        grant_n = Grant;
        s16_n   = S16;
        valid_n = Valid;
        cnt_n   = cnt;
        ptr_n   = ptr;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                load = any;
            end
            GRANT: begin
                if (Req[S16] && hold_ok) begin
                    cnt_n = (cnt < LAST) ? cnt + 4'd1 : cnt;
                end else if (any) begin
                    load = 1'b1;
                end else begin
                    state_n = IDLE;
                    grant_n = '0;
                    valid_n = 1'b0;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (load) begin
            state_n      = GRANT;
            s16_n        = win;
            grant_n      = '0;
            grant_n[win] = 1'b1;
            valid_n      = 1'b1;
            cnt_n        = '0;
            ptr_n        = win + 4'd1;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
            Grant <= '0;
            S16   <= '0;
            Valid <= 1'b0;
            cnt   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_n;
            Grant <= grant_n;
            S16   <= s16_n;
            Valid <= valid_n;
            cnt   <= cnt_n;
            ptr   <= ptr_n;
        end
    end

    assign f = Valid & W[S16];

endmodule
